// File: rtl/point_mult_sequencer.sv
// Scalar-multiplication sequencer: R = k*P by MSB-first double-and-add.
// It drives one external point_double unit and one point_add unit through
// their Reset/operand/Done handshake, and captures each result on Done.
//
// Ports:
//   clk, Reset         clock, synchronous active-high reset
//   Start, k, P        request, scalar and base point (registered on Start)
//   Busy, Done         operation in progress / result valid
//   R, R_inf           result point, result is the point at infinity
//   dbl_*              point_double handshake (Reset/P out, Done/R in)
//   add_*              point_add handshake (Reset/P/Q out, Done/R in)
//   cycles             busy-cycle counter, present with PM_CYCLE_COUNT_EN
//
// Build option: `define PM_CYCLE_COUNT_EN adds the 32-bit cycles output.

package pm_pkg;
    localparam int COORD_W = 256;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } curve_point_t;
endpackage

module point_mult_sequencer
    import pm_pkg::*;
#(
    parameter int K_WIDTH   = 256,
    parameter int CNT_WIDTH = 9
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [K_WIDTH-1:0] k,
    input  curve_point_t       P,
    output logic               Busy,
    output logic               Done,
    output curve_point_t       R,
    output logic               R_inf,
    output logic               dbl_Reset,
    output curve_point_t       dbl_P,
    input  logic               dbl_Done,
    input  curve_point_t       dbl_R,
    output logic               add_Reset,
    output curve_point_t       add_P,
    output curve_point_t       add_Q,
    input  logic               add_Done,
    input  curve_point_t       add_R
`ifdef PM_CYCLE_COUNT_EN
    ,
    output logic [31:0]        cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DBL_SETUP,
        S_DBL_WAIT,
        S_ADD_SETUP,
        S_ADD_WAIT,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] IDX_TOP = CNT_WIDTH'(K_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] IDX_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [K_WIDTH-1:0]   kreg_q, kreg_d;
    curve_point_t         preg_q, preg_d;
    curve_point_t         acc_q, acc_d;
    logic                 acc_inf_q, acc_inf_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    curve_point_t         r_q, r_d;
    logic                 r_inf_q, r_inf_d;

    logic cur_bit;
    logic idx_last;

    // Mask-and-reduce keeps every scalar bit in use for the selected bit.
    assign cur_bit  = |(kreg_q & (K_WIDTH'(1) << idx_q));
    assign idx_last = (idx_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            kreg_q    <= '0;
            preg_q    <= '0;
            acc_q     <= '0;
            acc_inf_q <= 1'b0;
            idx_q     <= '0;
            r_q       <= '0;
            r_inf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            kreg_q    <= kreg_d;
            preg_q    <= preg_d;
            acc_q     <= acc_d;
            acc_inf_q <= acc_inf_d;
            idx_q     <= idx_d;
            r_q       <= r_d;
            r_inf_q   <= r_inf_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        kreg_d    = kreg_q;
        preg_d    = preg_q;
        acc_d     = acc_q;
        acc_inf_d = acc_inf_q;
        idx_d     = idx_q;
        r_d       = r_q;
        r_inf_d   = r_inf_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    kreg_d    = k;
                    preg_d    = P;
                    idx_d     = IDX_TOP;
                    acc_d     = '0;
                    acc_inf_d = 1'b1;
                    r_d       = '0;
                    r_inf_d   = 1'b0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cur_bit) begin
                    // Leading one: acc = P without spending a unit operation.
                    acc_d     = preg_q;
                    acc_inf_d = 1'b0;
                    if (idx_last) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q - IDX_ONE;
                        state_d = S_DBL_SETUP;
                    end
                end else if (idx_last) begin
                    r_d     = '0;
                    r_inf_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            S_DBL_SETUP: state_d = S_DBL_WAIT;
            S_DBL_WAIT: begin
                if (dbl_Done) begin
                    acc_d = dbl_R;
                    if (cur_bit) begin
                        state_d = S_ADD_SETUP;
                    end else if (idx_last) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q - IDX_ONE;
                        state_d = S_DBL_SETUP;
                    end
                end
            end
            S_ADD_SETUP: state_d = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (add_Done) begin
                    acc_d = add_R;
                    if (idx_last) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q - IDX_ONE;
                        state_d = S_DBL_SETUP;
                    end
                end
            end
            S_FIN: begin
                r_d     = acc_q;
                r_inf_d = 1'b0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: units run only in their WAIT state, so operands taken
    // from acc/preg never change while a unit is out of reset.
    always_comb begin
        Busy      = !(state_q == S_IDLE || state_q == S_DONE);
        Done      = (state_q == S_DONE);
        dbl_Reset = (state_q != S_DBL_WAIT);
        add_Reset = (state_q != S_ADD_WAIT);
        R         = r_q;
        R_inf     = r_inf_q;
        dbl_P     = acc_q;
        add_P     = acc_q;
        add_Q     = preg_q;
    end

`ifdef PM_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    // The accept cycle counts as the first one, so the value in DONE
    // equals the Start-to-Done latency.
    always_comb begin
        cyc_d = cyc_q;
        if (Start && !Busy) begin
            cyc_d = 32'd1;
        end else if (Busy && cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycles = cyc_q;
`endif

endmodule
